// File: rtl/ocdve_apb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ocdve_apb_ctrl_pkg
// Description : Shared types and helpers for the round-robin APB master.
//               Provides the controller state encoding and the sizing
//               function for the ACCESS-phase timeout counter.
// Revision    : 1.0 - initial release
// ============================================================================
package ocdve_apb_ctrl_pkg;

  // APB transfer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_ctrl_state_e;

  // Width of a counter that must reach cycles-1. The result is never
  // below 1, so a disabled (0) or single-cycle timeout still yields a
  // legal vector.
  function automatic int tmo_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage : ocdve_apb_ctrl_pkg
`default_nettype wire

// File: rtl/ocdve_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ocdve_rr_arbiter
// Description : Round-robin arbiter. Picks the first requesting index at or
//               after the rotating pointer (wrapping), and moves the pointer
//               one past the winner whenever the owner accepts the grant.
// Revision    : 1.0 - initial release
// ============================================================================
module ocdve_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  // Highest-priority requester for the next arbitration.
  logic [IDX_W-1:0] ptr_q;

  assign any_o = |req_i;

  // Scan from the pointer upward, wrapping; first set request wins.
  always_comb begin
    int  idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    grant_o  = '0;
    winner_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        winner_o     = IDX_W'(idx);
      end
    end
  end

  // Rotate priority to just past the accepted winner.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else if (advance_i && any_o) begin
      if (int'(winner_o) == NUM_REQ - 1) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= winner_o + IDX_W'(1);
      end
    end
  end

endmodule : ocdve_rr_arbiter
`default_nettype wire

// File: rtl/ocdve_apb_rr_master.sv
`default_nettype none
// ============================================================================
// Module      : ocdve_apb_rr_master
// Description : APB master shared by NUM_REQ local requesters. Arbitrates
//               round-robin in IDLE, runs SETUP/ACCESS, and returns read
//               data, slave error and timeout status to the winner. All
//               outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module ocdve_apb_rr_master
  import ocdve_apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            req_grant_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
  output logic                          rsp_slverr_o,
  output logic                          rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0]         paddr_o,
  output logic                          psel_o,
  output logic                          penable_o,
  output logic                          pwrite_o,
  output logic [DATA_WIDTH-1:0]         pwdata_o,
  input  logic                          pready_i,
  input  logic [DATA_WIDTH-1:0]         prdata_i,
  input  logic                          pslverr_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = tmo_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  apb_ctrl_state_e         state_q;
  logic [NUM_REQ-1:0]      owner_q;
  logic [CNT_W-1:0]        tmo_cnt_q;
  logic [NUM_REQ-1:0]      req_grant_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_slverr_q;
  logic                    rsp_timeout_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;

  logic [NUM_REQ-1:0]      arb_grant;
  logic [IDX_W-1:0]        arb_winner;
  logic                    arb_any;
  logic                    arb_advance;

  // The pointer only moves when a grant is actually taken in IDLE.
  assign arb_advance = (state_q == ST_IDLE) && arb_any;

  ocdve_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arbiter (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (req_valid_i),
    .advance_i (arb_advance),
    .grant_o   (arb_grant),
    .winner_o  (arb_winner),
    .any_o     (arb_any)
  );

  // Transfer sequencer: arbitrate, SETUP, ACCESS with optional timeout.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      owner_q       <= '0;
      tmo_cnt_q     <= '0;
      req_grant_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
      paddr_q       <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
    end else begin
      // Grant and response are single-cycle pulses.
      req_grant_q <= '0;
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            req_grant_q <= arb_grant;
            owner_q     <= arb_grant;
            paddr_q     <= req_addr_i[int'(arb_winner)*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata_q    <= req_wdata_i[int'(arb_winner)*DATA_WIDTH +: DATA_WIDTH];
            pwrite_q    <= req_write_i[arb_winner];
            psel_q      <= 1'b1;
            state_q     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          tmo_cnt_q <= '0;
          state_q   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_i) begin
            rsp_valid_q   <= owner_q;
            rsp_rdata_q   <= pwrite_q ? '0 : prdata_i;
            rsp_slverr_q  <= pslverr_i;
            rsp_timeout_q <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= ST_IDLE;
          end else if ((TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST)) begin
            rsp_valid_q   <= owner_q;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            state_q       <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_grant_o   = req_grant_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_slverr_o  = rsp_slverr_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign paddr_o       = paddr_q;
  assign psel_o        = psel_q;
  assign penable_o     = penable_q;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = pwdata_q;

endmodule : ocdve_apb_rr_master
`default_nettype wire

// File: tb/tb_ocdve_apb_rr_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ocdve_apb_rr_master
// Description : Directed self-checking bench for ocdve_apb_rr_master with
//               NUM_REQ=4 and an 8-cycle ACCESS timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ocdve_apb_rr_master;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]    req_grant;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_slverr;
  logic             rsp_timeout;
  logic [AW-1:0]    paddr;
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [DW-1:0]    pwdata;
  logic             pready;
  logic [DW-1:0]    prdata;
  logic             pslverr;

  int total = 0;
  int bad   = 0;

  ocdve_apb_rr_master #(
    .NUM_REQ        (NR),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_valid_i   (req_valid),
    .req_write_i   (req_write),
    .req_addr_i    (req_addr),
    .req_wdata_i   (req_wdata),
    .req_grant_o   (req_grant),
    .rsp_valid_o   (rsp_valid),
    .rsp_rdata_o   (rsp_rdata),
    .rsp_slverr_o  (rsp_slverr),
    .rsp_timeout_o (rsp_timeout),
    .paddr_o       (paddr),
    .psel_o        (psel),
    .penable_o     (penable),
    .pwrite_o      (pwrite),
    .pwdata_o      (pwdata),
    .pready_i      (pready),
    .prdata_i      (prdata),
    .pslverr_i     (pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_write[i]         = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;
    pslverr   = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_grant", req_grant, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rdata", rsp_rdata, 0);
    reset = 1'b0;
    tick();

    // Single write, zero-wait slave
    pready = 1'b1;
    set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
    tick();
    chk("w0_grant", req_grant, 4'b0001);
    chk("w0_setup_psel", psel, 1);
    chk("w0_setup_pen", penable, 0);
    chk("w0_paddr", paddr, 32'h10);
    chk("w0_pwrite", pwrite, 1);
    chk("w0_pwdata", pwdata, 32'hA5A5_0001);
    req_valid[0] = 1'b0;
    tick();
    chk("w0_acc_psel", psel, 1);
    chk("w0_acc_pen", penable, 1);
    chk("w0_grant_pulse", req_grant, 0);
    tick();
    chk("w0_rsp_valid", rsp_valid, 4'b0001);
    chk("w0_slverr", rsp_slverr, 0);
    chk("w0_timeout", rsp_timeout, 0);
    chk("w0_rdata_zero", rsp_rdata, 0);
    chk("w0_done_psel", psel, 0);
    chk("w0_done_pen", penable, 0);
    chk("w0_hold_paddr", paddr, 32'h10);
    tick();
    chk("w0_rsp_pulse", rsp_valid, 0);

    // Read with three wait states on requester 2
    pready = 1'b0;
    set_req(2, 1'b0, 32'h40, 32'h0);
    tick();
    chk("r2_grant", req_grant, 4'b0100);
    chk("r2_pwrite", pwrite, 0);
    chk("r2_paddr", paddr, 32'h40);
    req_valid[2] = 1'b0;
    tick();
    chk("r2_pen_a1", penable, 1);
    tick();
    chk("r2_pen_a2", penable, 1);
    chk("r2_norsp_a2", rsp_valid, 0);
    tick();
    chk("r2_pen_a3", penable, 1);
    tick();
    chk("r2_pen_a4", penable, 1);
    chk("r2_norsp_a4", rsp_valid, 0);
    pready = 1'b1;
    prdata = 32'hDEAD_BEEF;
    tick();
    chk("r2_rsp_valid", rsp_valid, 4'b0100);
    chk("r2_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("r2_pen_off", penable, 0);

    // Fairness after wrap: pointer is at 3, requesters 1 and 3 valid
    prdata  = 32'h3333_0003;
    pslverr = 1'b1;
    set_req(1, 1'b1, 32'h100, 32'h11);
    set_req(3, 1'b0, 32'h300, 32'h0);
    tick();
    chk("wrap_grant3", req_grant, 4'b1000);
    chk("wrap_paddr3", paddr, 32'h300);
    req_valid[3] = 1'b0;
    tick();
    chk("wrap_no_grant_busy", req_grant, 0);
    tick();
    chk("wrap_rsp3", rsp_valid, 4'b1000);
    chk("wrap_rdata3", rsp_rdata, 32'h3333_0003);
    chk("wrap_slverr3", rsp_slverr, 1);
    chk("wrap_tmo3", rsp_timeout, 0);
    chk("wrap_idle_psel", psel, 0);
    pslverr = 1'b0;
    tick();
    chk("wrap_grant1", req_grant, 4'b0010);
    chk("wrap_paddr1", paddr, 32'h100);
    chk("wrap_pwdata1", pwdata, 32'h11);
    req_valid[1] = 1'b0;
    tick();
    tick();
    chk("wrap_rsp1", rsp_valid, 4'b0010);
    chk("wrap_slverr1", rsp_slverr, 0);
    chk("wrap_rdata1", rsp_rdata, 0);

    // Contention from reset: all four requesters valid
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pready = 1'b1;
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h1000 + 32'(4 * i), 32'h0);
    for (int i = 0; i < NR; i++) begin
      prdata = 32'hC0DE_0000 + 32'(i);
      tick();
      chk($sformatf("cont_grant%0d", i), req_grant, 64'(1) << i);
      chk($sformatf("cont_paddr%0d", i), paddr, 32'h1000 + 32'(4 * i));
      req_valid[i] = 1'b0;
      tick();
      chk($sformatf("cont_pen%0d", i), penable, 1);
      tick();
      chk($sformatf("cont_rsp%0d", i), rsp_valid, 64'(1) << i);
      chk($sformatf("cont_rdata%0d", i), rsp_rdata, 32'hC0DE_0000 + 32'(i));
      chk($sformatf("cont_gap%0d", i), psel, 0);
    end

    // Timeout: pready held low on requester 1
    pready = 1'b0;
    set_req(1, 1'b1, 32'h50, 32'h77);
    tick();
    chk("tmo_grant", req_grant, 4'b0010);
    req_valid[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("tmo_pen_a%0d", k), penable, 1);
      chk($sformatf("tmo_norsp_a%0d", k), rsp_valid, 0);
    end
    tick();
    chk("tmo_rsp", rsp_valid, 4'b0010);
    chk("tmo_slverr", rsp_slverr, 1);
    chk("tmo_flag", rsp_timeout, 1);
    chk("tmo_psel", psel, 0);
    chk("tmo_pen", penable, 0);
    pready = 1'b1;
    prdata = 32'h5A5A_5A5A;
    set_req(2, 1'b0, 32'h60, 32'h0);
    tick();
    chk("post_tmo_grant", req_grant, 4'b0100);
    req_valid[2] = 1'b0;
    tick();
    tick();
    chk("post_tmo_rsp", rsp_valid, 4'b0100);
    chk("post_tmo_flag", rsp_timeout, 0);
    chk("post_tmo_slverr", rsp_slverr, 0);
    chk("post_tmo_rdata", rsp_rdata, 32'h5A5A_5A5A);

    // Reset in the second ACCESS cycle
    pready = 1'b0;
    set_req(1, 1'b0, 32'h70, 32'h0);
    tick();
    chk("rsta_grant", req_grant, 4'b0010);
    req_valid[1] = 1'b0;
    tick();
    tick();
    chk("rsta_pen_a2", penable, 1);
    reset = 1'b1;
    #1;
    chk("rsta_psel_async", psel, 0);
    chk("rsta_pen_async", penable, 0);
    tick();
    chk("rsta_norsp", rsp_valid, 0);
    reset = 1'b0;
    pready = 1'b1;
    prdata = 32'h1234_5678;
    set_req(1, 1'b0, 32'h80, 32'h0);
    set_req(2, 1'b0, 32'h90, 32'h0);
    tick();
    chk("rsta_ptr_grant1", req_grant, 4'b0010);
    chk("rsta_norsp2", rsp_valid, 0);
    req_valid[1] = 1'b0;
    tick();
    tick();
    chk("rsta_rsp1", rsp_valid, 4'b0010);
    chk("rsta_rdata1", rsp_rdata, 32'h1234_5678);
    tick();
    chk("rsta_grant2", req_grant, 4'b0100);
    req_valid[2] = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ocdve_apb_rr_master
`default_nettype wire
